// File: rtl/arith_arbiter.sv
// Two-requester round-robin front end sharing one 4-bit ALU; results 1 cycle after accept (div: 5).
// Backpressure: result held in RESP until rsp_ready; no request is granted outside IDLE.
module arith_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [5:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result
);

  typedef enum logic [1:0] {IDLE, DIV, RESP} state_t;

  state_t     state, state_nxt;
  logic       ptr;
  logic [1:0] grant;
  logic       gid;
  logic       accept;
  logic [2:0] sel_op;
  logic [3:0] sel_a, sel_b;
  logic [4:0] sum5;
  logic [7:0] alu_res;
  logic [3:0] div_b, div_q, div_r;
  logic [1:0] div_cnt;
  logic [4:0] shift_r, trial;
  logic [3:0] r_nxt, q_nxt;

  // Pointer only arbitrates contention; a lone requester is granted directly.
  always_comb begin
    grant = 2'b00;
    if (!rst && state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign gid       = grant[1];
  assign sel_op    = gid ? req_op[5:3] : req_op[2:0];
  assign sel_a     = gid ? req_a[7:4]  : req_a[3:0];
  assign sel_b     = gid ? req_b[7:4]  : req_b[3:0];
  assign sum5      = {1'b0, sel_a} + {1'b0, sel_b};

  always_comb begin
    alu_res = 8'h00;
    case (sel_op)
      3'b000:  alu_res = {3'b000, sum5};
      3'b001:  alu_res = {4'h0, sel_a} - {4'h0, sel_b};
      3'b010:  alu_res = {4'h0, sel_a} * {4'h0, sel_b};
      3'b100:  alu_res = {4'h0, sel_a & sel_b};
      3'b101:  alu_res = {4'h0, sel_a | sel_b};
      3'b110:  alu_res = {4'h0, sel_a ^ sel_b};
      3'b111:  alu_res = {2'b00, (sel_a == sel_b), (sel_a != sel_b), (sel_a < sel_b),
                          (sel_a <= sel_b), (sel_a >= sel_b), (sel_a > sel_b)};
      default: alu_res = 8'h00;
    endcase
  end

  // One restoring step; with b=0 every trial succeeds, giving q=F and r=a naturally.
  always_comb begin
    shift_r = {div_r, div_q[3]};
    trial   = shift_r - {1'b0, div_b};
    if (!trial[4]) begin
      r_nxt = trial[3:0];
      q_nxt = {div_q[2:0], 1'b1};
    end else begin
      r_nxt = shift_r[3:0];
      q_nxt = {div_q[2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (sel_op == 3'b011) ? DIV : RESP;
      DIV:     if (div_cnt == 2'd3) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
      div_b      <= 4'h0;
      div_q      <= 4'h0;
      div_r      <= 4'h0;
      div_cnt    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= gid;
            if (req_valid == 2'b11) ptr <= ~gid;
            if (sel_op == 3'b011) begin
              div_b   <= sel_b;
              div_q   <= sel_a;
              div_r   <= 4'h0;
              div_cnt <= 2'd0;
            end else begin
              rsp_result <= alu_res;
            end
          end
        end
        DIV: begin
          div_r   <= r_nxt;
          div_q   <= q_nxt;
          div_cnt <= div_cnt + 2'd1;
          if (div_cnt == 2'd3) rsp_result <= {r_nxt, q_nxt};
        end
        RESP: begin
          if (rsp_ready) rsp_result <= 8'h00;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_arith_arbiter.sv
// Scoreboard bench for arith_arbiter: expected {id,result} queued at grant, checked at response.
module tb_arith_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_op;
  logic [7:0] req_a, req_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] sb_q[$];
  logic       mdl_ptr;

  arith_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input int a, input int b);
    int r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = (a - b + 256) % 256;
      3'd2: r = a * b;
      3'd3: r = (b == 0) ? ((a << 4) | 15) : (((a % b) << 4) | (a / b));
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ((a == b) << 5) | ((a != b) << 4) | ((a < b) << 3) |
                   ((a <= b) << 2) | ((a >= b) << 1) | (a > b ? 1 : 0);
    endcase
    return 8'(r);
  endfunction

  task automatic set_lane(input int id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id == 0) begin
      req_op = {3'($urandom), op};
      req_a  = {4'($urandom), a};
      req_b  = {4'($urandom), b};
    end else begin
      req_op = {op, 3'($urandom)};
      req_a  = {a, 4'($urandom)};
      req_b  = {b, 4'($urandom)};
    end
  endtask

  task automatic collect(input string tag);
    logic [8:0] e;
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_id"}, rsp_id, e[8]);
      chk({tag, "_res"}, rsp_result, e[7:0]);
    end
  endtask

  // Single requester op from IDLE; req_* are scrambled right after accept.
  task automatic issue(input int id, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input int exp_lat, input string tag);
    int lat;
    req_valid = 2'b01 << id;
    set_lane(id, op, a, b);
    #1;
    chk({tag, "_rdy"}, req_ready, 2'b01 << id);
    sb_q.push_back({1'(id), ref_op(op, a, b)});
    @(negedge clk);
    req_valid = 2'($urandom) & 2'b00;
    req_op = 6'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    if (exp_lat > 1) chk({tag, "_divres0"}, rsp_result, 8'h00);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    collect(tag);
    @(negedge clk);
    chk({tag, "_drop"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op = 6'h00; req_a = 8'h00; req_b = 8'h00;
    mdl_ptr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdy", req_ready, 2'b00);
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_res", rsp_result, 8'h00);
    chk("rst_id", rsp_id, 1'b0);
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);

    issue(0, 3'b010, 4'hF, 4'hF, 1, "mul_ff");

    // Contention: both requesters valid with fixed operands.
    req_valid = 2'b11;
    req_op = {3'b110, 3'b000}; req_a = 8'hA3; req_b = 8'h54;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] eg;
      int gi;
      gi = mdl_ptr ? 1 : 0;
      eg = 2'b01 << gi;
      #1;
      chk($sformatf("rr%0d_grant", i), req_ready, eg);
      sb_q.push_back({1'(gi), (gi == 0) ? ref_op(3'd0, 3, 4) : ref_op(3'd6, 10, 5)});
      mdl_ptr = ~mdl_ptr;
      @(negedge clk);
      chk($sformatf("rr%0d_busy", i), req_ready, 2'b00);
      collect($sformatf("rr%0d", i));
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);

    issue(1, 3'b011, 4'd13, 4'd4, 5, "div_13_4");
    issue(1, 3'b011, 4'd9, 4'd0, 5, "div_9_0");
    issue(0, 3'b111, 4'd5, 4'd9, 1, "cmp_5_9");
    issue(1, 3'b111, 4'd7, 4'd7, 1, "cmp_7_7");
    issue(0, 3'b001, 4'd3, 4'd5, 1, "sub_3_5");
    issue(1, 3'b000, 4'hF, 4'hF, 1, "add_f_f");
    issue(0, 3'b100, 4'hC, 4'hA, 1, "and");
    issue(1, 3'b110, 4'hC, 4'hA, 1, "xor");

    // Held response while requesters toggle.
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set_lane(0, 3'b101, 4'd9, 4'd6);
    #1;
    chk("stall_rdy", req_ready, 2'b01);
    sb_q.push_back({1'b0, ref_op(3'd5, 9, 6)});
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b11 ^ 2'(i);
      req_op = 6'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      #1;
      chk($sformatf("stall%0d_rdy", i), req_ready, 2'b00);
      chk($sformatf("stall%0d_vld", i), rsp_valid, 1'b1);
      chk($sformatf("stall%0d_res", i), rsp_result, ref_op(3'd5, 9, 6));
      chk($sformatf("stall%0d_id", i), rsp_id, 1'b0);
      @(negedge clk);
    end
    collect("stall");
    rsp_ready = 1'b1;
    req_valid = 2'b10;
    set_lane(1, 3'b000, 4'd1, 4'd2);
    @(negedge clk);
    chk("release_grant", req_ready, 2'b10);
    sb_q.push_back({1'b1, ref_op(3'd0, 1, 2)});
    @(negedge clk);
    req_valid = 2'b00;
    collect("release");
    @(negedge clk);

    // Reset during the second division cycle aborts the op.
    req_valid = 2'b10;
    set_lane(1, 3'b011, 4'd14, 4'd3);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    chk("abort_rdy", req_ready, 2'b00);
    chk("abort_vld", rsp_valid, 1'b0);
    chk("abort_res", rsp_result, 8'h00);
    chk("abort_id", rsp_id, 1'b0);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00; mdl_ptr = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_stale", seen, 0);
    issue(0, 3'b000, 4'd8, 4'd9, 1, "add_8_9");

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
